// File: rtl/branch_update_queue.sv
// Circular FIFO buffering resolved-branch updates (up to two per cycle) from execute
// and draining one per cycle, in program order, to the branch predictor.
module branch_update_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in0_valid_i,
  input  logic [ADDR_WIDTH-1:0]         in0_pc_i,
  input  logic                          in0_mispredict_i,
  input  logic                          in1_valid_i,
  input  logic [ADDR_WIDTH-1:0]         in1_pc_i,
  input  logic                          in1_mispredict_i,
  output logic                          ready_o,
  output logic                          update_prediction_valid_o,
  output logic [ADDR_WIDTH-1:0]         update_prediction_pc_o,
  output logic                          misprediction_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic [7:0]                    drop_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  mispredict;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     drop_q, drop_d;

  logic           ready;
  logic           pop;
  logic [1:0]     n_valid;
  logic [1:0]     pushes;
  logic           we0, we1;
  entry_t         wdata0, wdata1;
  logic [8:0]     drop_sum;
  entry_t         head_entry;

  always_comb begin
    ready      = (count_q <= CW'(DEPTH - 2));
    pop        = (count_q != '0);
    n_valid    = {1'b0, in0_valid_i} + {1'b0, in1_valid_i};
    pushes     = ready ? n_valid : 2'd0;
    // Lone in1 takes the tail slot so the queue stays gap-free.
    we0        = ready && (in0_valid_i || in1_valid_i);
    we1        = ready && in0_valid_i && in1_valid_i;
    wdata0     = in0_valid_i ? entry_t'{in0_pc_i, in0_mispredict_i}
                             : entry_t'{in1_pc_i, in1_mispredict_i};
    wdata1     = entry_t'{in1_pc_i, in1_mispredict_i};
    tail_d     = tail_q + PW'(pushes);
    head_d     = head_q + PW'(pop);
    count_d    = count_q + CW'(pushes) - CW'(pop);
    drop_sum   = {1'b0, drop_q} + 9'(n_valid);
    drop_d     = drop_q;
    if (!ready && (n_valid != 2'd0)) begin
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
    head_entry = mem_q[head_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we0) mem_q[tail_q] <= wdata0;
      if (we1) mem_q[PW'(tail_q + 1'b1)] <= wdata1;
    end
  end

  assign ready_o                   = ready;
  assign update_prediction_valid_o = pop;
  assign update_prediction_pc_o    = pop ? head_entry.pc : '0;
  assign misprediction_o           = pop ? head_entry.mispredict : 1'b0;
  assign count_o                   = count_q;
  assign drop_count_o              = drop_q;

endmodule
